peak_dpu_if_align: RTL and testbench



---
 rtl/peak_dpu_pkg.sv | 12 +
 rtl/peak_dpu_if_hwbuf.sv | 70 +++++++
 rtl/peak_dpu_if_align.sv | 85 ++++++++
 tb/tb_peak_dpu_if_align.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/peak_dpu_pkg.sv
// Shared types and helpers for the instruction fetch/align path.
// RVC detection and datapath widths.
package peak_dpu_pkg;

    localparam int PC_W = 32;
    localparam int HW_W = 16;

    function automatic logic is_rvc(input logic [1:0] op);
        return op != 2'b11;
    endfunction

endpackage

// File: rtl/peak_dpu_if_hwbuf.sv
// Halfword FIFO for the instruction aligner.
// Pushes and pops up to two halfwords per cycle; flush empties it.
module peak_dpu_if_hwbuf
    import peak_dpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1),
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [1:0]      push_n,
    input  logic [HW_W-1:0] push_hw0,
    input  logic [HW_W-1:0] push_hw1,
    input  logic [1:0]      pop_n,
    output logic [HW_W-1:0] hw0,
    output logic [HW_W-1:0] hw1,
    output logic [CW-1:0]   cnt
);

    logic [HW_W-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   wr_ptr1;
    logic [PW-1:0]   rd_ptr1;

    function automatic logic [PW-1:0] wrap_add(
        input logic [PW-1:0] p,
        input logic [1:0]    n
    );
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    // Read-side and second-write addresses, wrapping modulo DEPTH.
    always_comb begin
        rd_ptr1 = wrap_add(rd_ptr, 2'd1);
        wr_ptr1 = wrap_add(wr_ptr, 2'd1);
        hw0     = mem[rd_ptr];
        hw1     = mem[rd_ptr1];
    end

    // Storage is not reset; entries beyond cnt are never observed.
    always_ff @(posedge clk) begin
        if (!flush && push_n != 2'd0) mem[wr_ptr] <= push_hw0;
        if (!flush && push_n == 2'd2) mem[wr_ptr1] <= push_hw1;
    end

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            rd_ptr <= wrap_add(rd_ptr, pop_n);
            wr_ptr <= wrap_add(wr_ptr, push_n);
            cnt    <= cnt + {{(CW-2){1'b0}}, push_n}
                          - {{(CW-2){1'b0}}, pop_n};
        end
    end

endmodule

// File: rtl/peak_dpu_if_align.sv
// Instruction aligner: fetch words in, one RV32IC instruction out.
// Handles straddling 32-bit ops, odd-halfword redirects, backpressure.
module peak_dpu_if_align
    import peak_dpu_pkg::*;
#(
    parameter int          HW_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_vld,
    output logic            fetch_rdy,
    input  logic [31:0]     fetch_data,
    input  logic            redirect_vld,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            instr_vld,
    input  logic            instr_rdy,
    output logic [31:0]     instr_op,
    output logic            instr_is_compressed,
    output logic [PC_W-1:0] instr_pc
);

    localparam int CW = $clog2(HW_DEPTH + 1);

    logic [HW_W-1:0] hw0;
    logic [HW_W-1:0] hw1;
    logic [CW-1:0]   cnt;
    logic [PC_W-1:0] head_pc;
    logic            drop_lo;
    logic            head_rvc;
    logic            push_ok;
    logic            pop_ok;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    logic [HW_W-1:0] push_hw0;

    peak_dpu_if_hwbuf #(
        .DEPTH (HW_DEPTH)
    ) u_hwbuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_vld),
        .push_n   (push_n),
        .push_hw0 (push_hw0),
        .push_hw1 (fetch_data[31:16]),
        .pop_n    (pop_n),
        .hw0      (hw0),
        .hw1      (hw1),
        .cnt      (cnt)
    );

    // Head classification and handshake decode, all from registered state.
    always_comb begin
        fetch_rdy = cnt <= CW'(HW_DEPTH - 2);
        head_rvc  = is_rvc(hw0[1:0]);
        instr_vld = head_rvc ? (cnt >= CW'(1)) : (cnt >= CW'(2));
        instr_op  = 32'h0;
        if (instr_vld)
            instr_op = head_rvc ? {16'h0, hw0} : {hw1, hw0};
        instr_is_compressed = instr_vld & head_rvc;
        instr_pc  = head_pc;
        push_ok   = fetch_vld & fetch_rdy & ~redirect_vld;
        pop_ok    = instr_vld & instr_rdy & ~redirect_vld;
        push_n    = push_ok ? (drop_lo ? 2'd1 : 2'd2) : 2'd0;
        push_hw0  = drop_lo ? fetch_data[31:16] : fetch_data[15:0];
        pop_n     = pop_ok ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
    end

    // Head PC and odd-halfword drop flag; redirect has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_pc <= RESET_PC;
            drop_lo <= 1'b0;
        end else if (redirect_vld) begin
            head_pc <= {redirect_pc[31:1], 1'b0};
            drop_lo <= redirect_pc[1];
        end else begin
            if (pop_ok)
                head_pc <= head_pc + (head_rvc ? 32'd2 : 32'd4);
            if (push_ok)
                drop_lo <= 1'b0;
        end
    end

endmodule

// File: tb/tb_peak_dpu_if_align.sv
// Bench for the instruction aligner.
// Queue-of-halfwords reference model plus directed and random traffic.
module tb_peak_dpu_if_align;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic [31:0] fetch_data;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        instr_vld;
    logic        instr_rdy;
    logic [31:0] instr_op;
    logic        instr_is_compressed;
    logic [31:0] instr_pc;

    int checks = 0;
    int errors = 0;

    logic [15:0] mq [$];
    logic [31:0] m_pc;
    logic        m_drop;

    always #5 clk = ~clk;

    peak_dpu_if_align #(
        .HW_DEPTH (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fetch_vld           (fetch_vld),
        .fetch_rdy           (fetch_rdy),
        .fetch_data          (fetch_data),
        .redirect_vld        (redirect_vld),
        .redirect_pc         (redirect_pc),
        .instr_vld           (instr_vld),
        .instr_rdy           (instr_rdy),
        .instr_op            (instr_op),
        .instr_is_compressed (instr_is_compressed),
        .instr_pc            (instr_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RPC;
        m_drop = 1'b0;
    endtask

    function automatic bit m_vld();
        if (mq.size() == 0) return 1'b0;
        if (mq[0][1:0] != 2'b11) return 1'b1;
        return mq.size() >= 2;
    endfunction

    function automatic bit m_rvc();
        return mq.size() > 0 && mq[0][1:0] != 2'b11;
    endfunction

    function automatic bit m_frdy();
        return mq.size() <= DEPTH - 2;
    endfunction

    task automatic check_model();
        chk("vld", 32'(instr_vld), 32'(m_vld()));
        chk("frdy", 32'(fetch_rdy), 32'(m_frdy()));
        chk("pc", instr_pc, m_pc);
        if (m_vld()) begin
            chk("cmp", 32'(instr_is_compressed), 32'(m_rvc()));
            if (m_rvc()) chk("op", instr_op, {16'h0, mq[0]});
            else         chk("op", instr_op, {mq[1], mq[0]});
        end
    endtask

    task automatic model_step(input bit fv, input logic [31:0] fd,
                              input bit rv, input logic [31:0] rp,
                              input bit ir);
        bit v, c, fr;
        v  = m_vld();
        c  = m_rvc();
        fr = m_frdy();
        if (rv) begin
            mq.delete();
            m_pc   = {rp[31:1], 1'b0};
            m_drop = rp[1];
        end else begin
            if (v && ir) begin
                void'(mq.pop_front());
                if (!c) void'(mq.pop_front());
                m_pc = m_pc + (c ? 32'd2 : 32'd4);
            end
            if (fv && fr) begin
                if (!m_drop) mq.push_back(fd[15:0]);
                mq.push_back(fd[31:16]);
                m_drop = 1'b0;
            end
        end
    endtask

    // Called at a negedge: check, drive for the next edge, advance model.
    task automatic cyc(input bit fv, input logic [31:0] fd,
                       input bit rv, input logic [31:0] rp,
                       input bit ir);
        check_model();
        fetch_vld    = fv;
        fetch_data   = fd;
        redirect_vld = rv;
        redirect_pc  = rp;
        instr_rdy    = ir;
        model_step(fv, fd, rv, rp, ir);
        @(negedge clk);
    endtask

    task automatic check_reset();
        chk("rst_vld", 32'(instr_vld), 32'h0);
        chk("rst_frdy", 32'(fetch_rdy), 32'h1);
        chk("rst_cmp", 32'(instr_is_compressed), 32'h0);
        chk("rst_op", instr_op, 32'h0);
        chk("rst_pc", instr_pc, RPC);
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1, 0) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit          fv, rv, ir;
            logic [31:0] fd, rp;
            fv = $urandom_range(9, 0) < 7;
            rv = $urandom_range(29, 0) == 0;
            ir = $urandom_range(9, 0) < 7;
            fd = {rand_hw(), rand_hw()};
            rp = $urandom;
            if ($urandom_range(7, 0) == 0) rp = 32'hFFFF_FFFA;
            cyc(fv, fd, rv, rp, ir);
        end
    endtask

    initial begin
        rst          = 1'b1;
        fetch_vld    = 1'b0;
        fetch_data   = 32'h0;
        redirect_vld = 1'b0;
        redirect_pc  = 32'h0;
        instr_rdy    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset();

        cyc(1, 32'h00A00093, 0, 0, 1);
        chk("p1_vld", 32'(instr_vld), 32'h1);
        chk("p1_op", instr_op, 32'h00A00093);
        chk("p1_cmp", 32'(instr_is_compressed), 32'h0);
        cyc(0, 0, 0, 0, 1);
        chk("p1_after", 32'(instr_vld), 32'h0);

        cyc(1, 32'h00010001, 0, 0, 1);
        chk("c1_op", instr_op, 32'h00000001);
        chk("c1_pc", instr_pc, 32'h4);
        cyc(0, 0, 0, 0, 1);
        chk("c2_pc", instr_pc, 32'h6);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 32'h00930001, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("st_wait", 32'(instr_vld), 32'h0);
        cyc(1, 32'h000100A0, 0, 0, 1);
        chk("st_op", instr_op, 32'h00A00093);
        cyc(0, 0, 0, 0, 1);
        chk("st_tail", instr_op, 32'h00000001);
        cyc(0, 0, 0, 0, 1);

        cyc(0, 0, 1, 32'h102, 1);
        cyc(1, 32'h40810001, 0, 0, 1);
        chk("rd_op", instr_op, 32'h00004081);
        chk("rd_pc", instr_pc, 32'h102);
        cyc(0, 0, 1, 32'h0, 1);

        for (int i = 0; i < 4; i++) cyc(1, 32'h00A00093, 0, 0, 0);
        chk("bp_frdy", 32'(fetch_rdy), 32'h0);
        chk("bp_op", instr_op, 32'h00A00093);
        chk("bp_pc", instr_pc, 32'h0);
        cyc(0, 0, 0, 0, 1);
        chk("bp_pc2", instr_pc, 32'h4);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        rand_cycles(600);

        cyc(1, 32'h00010001, 0, 0, 0);
        cyc(1, 32'h00A00093, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check_reset();
        model_reset();
        fetch_vld    = 1'b0;
        redirect_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        rand_cycles(600);
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
